// File: rtl/psum_collector_pkg.sv
// Shared definitions for the partial-sum collector: default geometry, ID width helper and the
// FIFO entry layout for the default configuration.
package psum_collector_pkg;

  localparam int unsigned DefaultDataWidth = 16;
  localparam int unsigned DefaultNumCol    = 10;

  // Column IDs carry one extra bit beyond the minimum index width.
  function automatic int unsigned id_width(int unsigned n);
    return $clog2(n) + 1;
  endfunction

  localparam int unsigned DefaultIdWidth = id_width(DefaultNumCol);

  typedef struct packed {
    logic [DefaultIdWidth-1:0]   id;
    logic [DefaultDataWidth-1:0] data;
  } psum_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant over masked requests, searching from the slot after the
// last grant. The pointer only advances on an enabled cycle that actually grants.
module rr_arbiter #(
  parameter int unsigned NumReq = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [NumReq-1:0] req_i,
  input  logic [NumReq-1:0] mask_i,
  output logic [NumReq-1:0] gnt_o
);

  localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [PtrW-1:0]   last_q, last_d;
  logic [PtrW-1:0]   idx;
  logic [NumReq-1:0] req_m;
  logic              found;

  assign req_m = req_i & mask_i;

  // A stale pointer at or beyond the active limit wraps through masked slots to column 0.
  always_comb begin
    gnt_o  = '0;
    last_d = last_q;
    found  = 1'b0;
    idx    = '0;
    if (en_i) begin
      for (int unsigned k = 0; k < NumReq; k++) begin
        idx = PtrW'((32'(last_q) + 32'd1 + k) % NumReq);
        if (!found && req_m[idx]) begin
          found      = 1'b1;
          gnt_o[idx] = 1'b1;
          last_d     = idx;
        end
      end
    end
    if (clr_i) begin
      last_d = PtrW'(NumReq - 1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q <= PtrW'(NumReq - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/psum_collector.sv
// Collects PE partial sums through a round-robin arbiter into a first-word fall-through FIFO,
// tagging each entry with its source column.
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned NUM_COL    = DefaultNumCol,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          flush,
  input  logic [7:0]                    kernel_size,
  input  logic [NUM_COL-1:0]            pe_valid,
  input  logic [NUM_COL*DATA_WIDTH-1:0] pe_data,
  output logic [NUM_COL-1:0]            pe_ack,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [id_width(NUM_COL)-1:0]  out_id,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned IdW  = id_width(NUM_COL);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [IdW-1:0]        id;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t            mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [NUM_COL-1:0] col_mask;
  logic [NUM_COL-1:0] grant;
  logic              full, pop, push, arb_en;
  entry_t            push_entry;

  // Columns at or above kernel_size are inactive; values above NUM_COL enable every column.
  always_comb begin
    col_mask = '0;
    for (int unsigned i = 0; i < NUM_COL; i++) begin
      col_mask[i] = (i < 32'(kernel_size));
    end
  end

  assign full      = (count_q == CntW'(FIFO_DEPTH));
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready && !flush;
  assign arb_en    = rstn && !flush && (!full || pop);

  rr_arbiter #(
    .NumReq (NUM_COL)
  ) u_rr_arbiter (
    .clk_i  (clk),
    .rst_ni (rstn),
    .clr_i  (flush),
    .en_i   (arb_en),
    .req_i  (pe_valid),
    .mask_i (col_mask),
    .gnt_o  (grant)
  );

  assign pe_ack = grant;
  assign push   = |grant;

  always_comb begin
    push_entry = '0;
    for (int unsigned i = 0; i < NUM_COL; i++) begin
      if (grant[i]) begin
        push_entry.id   = IdW'(i);
        push_entry.data = pe_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only exposed while the occupancy is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign out_data   = out_valid ? mem_q[rd_ptr_q].data : '0;
  assign out_id     = out_valid ? mem_q[rd_ptr_q].id : '0;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_psum_collector.sv
// Bench for psum_collector: directed scenarios plus randomized traffic, all checked cycle by
// cycle against a queue-based reference model.
module tb_psum_collector;

  localparam int unsigned DW = 16;
  localparam int unsigned NC = 10;
  localparam int unsigned FD = 4;
  localparam int unsigned IW = $clog2(NC) + 1;
  localparam int unsigned CW = $clog2(FD) + 1;

  logic             clk = 1'b0;
  logic             rstn, flush, out_ready, out_valid;
  logic [7:0]       kernel_size;
  logic [NC-1:0]    pe_valid, pe_ack;
  logic [NC*DW-1:0] pe_data;
  logic [DW-1:0]    out_data;
  logic [IW-1:0]    out_id;
  logic [CW-1:0]    fifo_count;

  always #5 clk = ~clk;

  psum_collector #(
    .DATA_WIDTH (DW),
    .NUM_COL    (NC),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .flush       (flush),
    .kernel_size (kernel_size),
    .pe_valid    (pe_valid),
    .pe_data     (pe_data),
    .pe_ack      (pe_ack),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_id      (out_id),
    .fifo_count  (fifo_count)
  );

  typedef struct {
    int id;
    int data;
  } ent_t;

  ent_t          mq[$];
  logic [NC-1:0] ack_log[$];
  int            last_g = NC - 1;
  int            last_ack = -1;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // An acked PE withdraws its result.
  task automatic retire();
    if (last_ack >= 0) pe_valid[last_ack] = 1'b0;
  endtask

  task automatic present(input logic [NC-1:0] m);
    for (int i = 0; i < NC; i++) begin
      if (m[i] && !pe_valid[i]) begin
        pe_valid[i] = 1'b1;
        pe_data[i*DW +: DW] = DW'($urandom);
      end
    end
  endtask

  function automatic int count_acks();
    int n = 0;
    foreach (ack_log[k]) if (ack_log[k] != '0) n++;
    return n;
  endfunction

  // Called #1 after a rising edge with inputs already applied.
  task automatic run_cycle();
    int            lim, start, c, g;
    bit            can;
    logic [NC-1:0] exp_ack;
    #1;
    lim = (int'(kernel_size) > NC) ? NC : int'(kernel_size);
    can = (mq.size() < FD) || (out_ready && mq.size() > 0);
    g = -1;
    if (rstn && !flush && can) begin
      start = (last_g >= lim) ? 0 : (last_g + 1) % NC;
      for (int k = 0; k < NC; k++) begin
        c = (start + k) % NC;
        if (g < 0 && c < lim && pe_valid[c]) g = c;
      end
    end
    exp_ack = '0;
    if (g >= 0) exp_ack[g] = 1'b1;
    check("pe_ack", 32'(pe_ack), 32'(exp_ack));
    check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    check("out_data", 32'(out_data), (mq.size() > 0) ? 32'(mq[0].data) : 32'd0);
    check("out_id", 32'(out_id), (mq.size() > 0) ? 32'(mq[0].id) : 32'd0);
    check("fifo_count", 32'(fifo_count), 32'(mq.size()));
    ack_log.push_back(pe_ack);
    @(posedge clk);
    if (!rstn || flush) begin
      mq.delete();
      last_g = NC - 1;
    end else begin
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (g >= 0) begin
        mq.push_back('{g, int'(pe_data[g*DW +: DW])});
        last_g = g;
      end
    end
    last_ack = g;
    #1;
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; out_ready = 1'b0; kernel_size = 8'd0;
    pe_valid = '0; pe_data = '0;
    @(posedge clk);
    #1;
    repeat (2) run_cycle();

    // Single source.
    rstn = 1'b1; kernel_size = 8'd3; out_ready = 1'b1;
    pe_valid[1] = 1'b1; pe_data[1*DW +: DW] = 16'h00A5;
    ack_log.delete();
    repeat (3) begin retire(); run_cycle(); end
    check("single_ack", 32'(ack_log[0]), 32'h2);
    check("single_acks", 32'(count_acks()), 32'd1);

    // Fairness from a cleared pointer.
    flush = 1'b1; retire(); run_cycle(); flush = 1'b0;
    ack_log.delete();
    repeat (6) begin retire(); present(NC'(7)); run_cycle(); end
    for (int k = 0; k < 6; k++) check("fair_order", 32'(ack_log[k]), 32'(1 << (k % 3)));

    // Masked column.
    kernel_size = 8'd2; pe_valid = '0;
    ack_log.delete();
    repeat (5) begin retire(); pe_valid[5] = 1'b1; run_cycle(); end
    check("mask_acks", 32'(count_acks()), 32'd0);
    check("mask_count", 32'(fifo_count), 32'd0);

    // Backpressure.
    out_ready = 1'b0; kernel_size = 8'd7; pe_valid = '0;
    ack_log.delete();
    repeat (8) begin retire(); present(NC'(15)); run_cycle(); end
    check("bp_acks", 32'(count_acks()), 32'd4);
    check("bp_count", 32'(fifo_count), 32'd4);
    ack_log.delete();
    out_ready = 1'b1; retire(); present(NC'(15)); run_cycle(); out_ready = 1'b0;
    check("bp_pop_ack", 32'(count_acks()), 32'd1);
    check("bp_pop_count", 32'(fifo_count), 32'd4);

    // Flush with three entries held.
    flush = 1'b1; retire(); run_cycle(); flush = 1'b0;
    pe_valid = '0; kernel_size = 8'd3;
    repeat (3) begin retire(); present(NC'(7)); run_cycle(); end
    check("flush_pre", 32'(fifo_count), 32'd3);
    flush = 1'b1; retire(); present(NC'(7));
    ack_log.delete(); run_cycle(); flush = 1'b0;
    check("flush_ack", 32'(ack_log[0]), 32'd0);
    check("flush_count", 32'(fifo_count), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    ack_log.delete(); retire(); present(NC'(7)); run_cycle();
    check("flush_next", 32'(ack_log[0]), 32'h1);

    // Reset mid-operation with PE2 left pending.
    out_ready = 1'b0;
    repeat (6) begin retire(); present(NC'(3)); run_cycle(); end
    retire(); pe_valid = '0; present(NC'(4));
    rstn = 1'b0;
    repeat (2) run_cycle();
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    rstn = 1'b1; ack_log.delete(); retire(); run_cycle();
    check("rst_ack", 32'(ack_log[0]), 32'h4);

    // Randomized traffic at three downstream duty levels.
    for (int seg = 0; seg < 3; seg++) begin
      repeat (1000) begin
        retire();
        for (int i = 0; i < NC; i++) begin
          if (pe_valid[i] && $urandom_range(99) < 3) pe_valid[i] = 1'b0;
          else if (!pe_valid[i] && $urandom_range(99) < 40) present(NC'(1) << i);
        end
        if ($urandom_range(99) < 5) kernel_size = 8'($urandom_range(12));
        out_ready = ($urandom_range(99) < (seg == 0 ? 20 : (seg == 1 ? 60 : 95)));
        flush = ($urandom_range(99) < 2);
        rstn = !($urandom_range(99) < 1);
        run_cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
